// File: rtl/hit_tracker_if.sv
// Bus between the light/button front end and the hit_tracker scoring stage.
// The master drives round control, lights and raw buttons; the slave returns counters and strobes.
interface hit_tracker_if #(
    parameter int unsigned NUM_HOLES = 9,
    parameter int unsigned SCORE_W   = 8
);
    logic                 start;
    logic [NUM_HOLES-1:0] lights;
    logic [NUM_HOLES-1:0] buttons;
    logic [SCORE_W-1:0]   score;
    logic [SCORE_W-1:0]   misses;
    logic [SCORE_W-1:0]   wrong;
    logic [SCORE_W-1:0]   streak;
    logic [SCORE_W-1:0]   best_streak;
    logic                 hit_pulse;
    logic                 miss_pulse;
    logic                 round_done;

    modport master (
        output start, lights, buttons,
        input  score, misses, wrong, streak, best_streak, hit_pulse, miss_pulse, round_done
    );

    modport slave (
        input  start, lights, buttons,
        output score, misses, wrong, streak, best_streak, hit_pulse, miss_pulse, round_done
    );
endinterface

// File: rtl/hit_tracker.sv
// Whack-a-mole scoring: classifies each light flick as hit/miss, counts wrong presses, flags round end.
// Define HIT_TRACKER_DEBOUNCE_EN to insert a per-button debounce counter ahead of edge detection.
module hit_tracker #(
    parameter int unsigned NUM_HOLES       = 9,
    parameter int unsigned ROUND_FLICKS    = 30,
    parameter int unsigned SCORE_W         = 8,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic          clk,
    input  logic          reset,
    hit_tracker_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        WINDOW,
        SCORED,
        DONE
    } state_t;

    localparam logic [5:0] LAST_FLICK = 6'(ROUND_FLICKS);

    if (ROUND_FLICKS < 1 || ROUND_FLICKS > 63 || DEBOUNCE_CYCLES == 20'd0) begin : g_param_check
        $error("hit_tracker: ROUND_FLICKS must be 1..63 and DEBOUNCE_CYCLES nonzero");
    end

    state_t               state, state_next;
    logic [NUM_HOLES-1:0] sync1, sync2, prev, edge_src, press;
    logic [NUM_HOLES-1:0] target;
    logic [5:0]           flicks, flick_next;
    logic                 last_close;

    logic [SCORE_W-1:0]   score_q, misses_q, wrong_q, streak_q, best_q;
    logic                 hit_pulse_q, miss_pulse_q, round_done_q;

    logic                 do_clear, do_hit, do_miss, do_wrong, do_close;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= bus.buttons;
            sync2 <= sync1;
            prev  <= edge_src;
        end
    end

`ifdef HIT_TRACKER_DEBOUNCE_EN
    logic [NUM_HOLES-1:0] db;
    logic [19:0]          db_cnt [NUM_HOLES];

    // Each bit flips only after the synchronized input disagrees for a full run of cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            db <= '0;
            for (int unsigned i = 0; i < NUM_HOLES; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_HOLES; i++) begin
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == DEBOUNCE_CYCLES - 20'd1) begin
                        db[i]     <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 20'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign edge_src = db;
`else
    assign edge_src = sync2;
`endif

    assign press      = edge_src & ~prev;
    assign flick_next = flicks + 6'd1;
    assign last_close = (flick_next == LAST_FLICK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) state_next = ARMED;
            end
            ARMED: begin
                if (!bus.start) begin
                    state_next = IDLE;
                end else if (|bus.lights) begin
                    state_next = (|(press & bus.lights)) ? SCORED : WINDOW;
                end
            end
            WINDOW: begin
                if (!bus.start)    state_next = IDLE;
                else if (do_close) state_next = last_close ? DONE : ARMED;
                else if (do_hit)   state_next = SCORED;
            end
            SCORED: begin
                if (!bus.start)    state_next = IDLE;
                else if (do_close) state_next = last_close ? DONE : ARMED;
            end
            DONE: begin
                if (!bus.start) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Event strobes; a hit on the closing cycle suppresses the miss but still closes the flick.
    always_comb begin
        do_clear = 1'b0;
        do_hit   = 1'b0;
        do_miss  = 1'b0;
        do_wrong = 1'b0;
        do_close = 1'b0;
        case (state)
            IDLE: begin
                do_clear = bus.start;
            end
            ARMED: begin
                if (bus.start) begin
                    if (|bus.lights) begin
                        do_hit = |(press & bus.lights);
                    end else begin
                        do_wrong = |press;
                    end
                end
            end
            WINDOW: begin
                if (bus.start) begin
                    do_hit   = |(press & target);
                    do_wrong = !do_hit && (|press);
                    do_close = ~|bus.lights;
                    do_miss  = do_close && !do_hit;
                end
            end
            SCORED: begin
                do_close = bus.start && (~|bus.lights);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            target       <= '0;
            flicks       <= '0;
            score_q      <= '0;
            misses_q     <= '0;
            wrong_q      <= '0;
            streak_q     <= '0;
            best_q       <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            round_done_q <= 1'b0;
        end else begin
            hit_pulse_q  <= do_hit;
            miss_pulse_q <= do_miss;
            round_done_q <= (state_next == DONE);
            if (state == ARMED && bus.start && (|bus.lights)) begin
                target <= bus.lights;
            end
            if (do_clear) begin
                flicks   <= '0;
                score_q  <= '0;
                misses_q <= '0;
                wrong_q  <= '0;
                streak_q <= '0;
                best_q   <= '0;
            end else begin
                if (do_hit) begin
                    score_q  <= sat_inc(score_q);
                    streak_q <= sat_inc(streak_q);
                    if (sat_inc(streak_q) > best_q) begin
                        best_q <= sat_inc(streak_q);
                    end
                end
                if (do_miss) begin
                    misses_q <= sat_inc(misses_q);
                    streak_q <= '0;
                end
                if (do_wrong) begin
                    wrong_q <= sat_inc(wrong_q);
                end
                if (do_close) begin
                    flicks <= flick_next;
                end
            end
        end
    end

    assign bus.score       = score_q;
    assign bus.misses      = misses_q;
    assign bus.wrong       = wrong_q;
    assign bus.streak      = streak_q;
    assign bus.best_streak = best_q;
    assign bus.hit_pulse   = hit_pulse_q;
    assign bus.miss_pulse  = miss_pulse_q;
    assign bus.round_done  = round_done_q;

endmodule

// File: doc/hit_tracker.md
# hit_tracker

Scoring stage downstream of the light controller in the whack-a-mole datapath. It watches the one-hot `lights` vector, samples the nine player buttons, and classifies every light flick. Each flick ends as a hit or a miss, and presses on dark holes count as wrong presses. It keeps saturating score, miss, wrong and streak counters and flags the end of a round after a fixed number of flicks, for the display and game-top FSM.

## Interface
Parameters:
- `NUM_HOLES`, 9: width of `lights`/`buttons`.
- `ROUND_FLICKS`, 30: closed flicks per round (1–63).
- `SCORE_W`, 8: width of all counters.
- `DEBOUNCE_CYCLES`, 20'd500000: stable cycles required per button (used only with the debounce macro).

Ports:
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high; clears all state on the next `clk` rising edge.
- `start` input 1: level; the round runs while high.
- `lights` input NUM_HOLES: registered one-hot light vector from the light controller; 0 means no light.
- `buttons` input NUM_HOLES: raw asynchronous buttons, active-high.
- `score` output SCORE_W: hits this round.
- `misses` output SCORE_W: flicks that closed without a hit.
- `wrong` output SCORE_W: press edges that were not on the lit hole.
- `streak` output SCORE_W: current consecutive hits.
- `best_streak` output SCORE_W: maximum `streak` this round.
- `hit_pulse` output 1: one cycle per hit.
- `miss_pulse` output 1: one cycle per miss.
- `round_done` output 1: high in DONE.

## Operation
- **Reset:** all outputs 0, state IDLE, target 0, flick count 0, button pipeline 0.
- **Button path:** a 2-flop synchronizer, then a previous-value register. `press[i]` = sync[i] & ~prev[i], so it is one cycle per rising edge. Multiple bits may be set in the same cycle.
- **Counters:** all counters saturate at 2^SCORE_W−1. The flick count is 6 bits and internal.
- **IDLE:** if `start` is high, go to ARMED and clear all counters and the flick count.
- **ARMED** (no light latched):
  - `lights`≠0 and `press` & `lights` ≠0: hit. Latch target = `lights`, go to SCORED.
  - `lights`≠0 otherwise: latch target = `lights`, go to WINDOW.
  - `lights`=0 and `press`≠0: `wrong`+1 (one increment per cycle regardless of how many bits are set).
- **WINDOW:**
  - `press` & target ≠0: hit. `score`+1, `streak`+1, `best_streak` = max(best_streak, streak+1), `hit_pulse`=1. Other bits pressed in the same cycle are ignored.
  - Otherwise, if `press`≠0: `wrong`+1.
  - `lights`=0: flick closes.
    - If there was no hit in this cycle: `misses`+1, `streak`=0, `miss_pulse`=1.
    - Flick count +1. If the new count equals ROUND_FLICKS, go to DONE; else go to ARMED.
  - A hit and `lights`=0 in the same cycle: the hit wins (no miss), and the flick closes.
  - A hit without the light closing: go to SCORED.
- **SCORED:** presses are ignored. When `lights`=0, flick count +1 and go to DONE or ARMED as above.
- **DONE:** counters are held and `round_done`=1. When `start` is low, go to IDLE; counters keep their values until the next start.
- **`start` low in ARMED/WINDOW/SCORED:** go to IDLE immediately. Counters are held and no miss is charged.
- **`reset` mid-round:** overrides everything; all state clears at the next edge.

## Timing
- Every output is a register; none is combinational from an input.
- `lights` observed ≠0 in cycle n: the state reflects WINDOW/SCORED after edge n+1.
- Raw button rise sampled at edge k (debounce disabled):
  - `press` is high in the cycle after edge k+1.
  - The counter and `hit_pulse` update at edge k+2.
- With debounce enabled, add DEBOUNCE_CYCLES cycles to that latency.
- `lights` becoming 0 in cycle n: `miss_pulse`/`misses` update at edge n+1.
- `round_done` rises at the same edge the last flick closes.
- Pulses are exactly one cycle wide. `hit_pulse` and `miss_pulse` are never high together.

## Configuration
- **`HIT_TRACKER_DEBOUNCE_EN` defined:** each synchronized button feeds a per-bit counter. The debounced bit toggles only after the input differs from it for DEBOUNCE_CYCLES consecutive cycles. Edge detection uses the debounced bit.
- **Not defined:** no debounce logic; edge detection runs directly on the 2-flop synchronizer output. DEBOUNCE_CYCLES is unused.
- Benches run without the macro unless stated.

## Test plan
- **Reset:** reset held 2 cycles during an active round -> all outputs 0, state IDLE. `start`=1 then moves to ARMED the next cycle.
- **Hit:** `lights`=9'b000010000 for 20 cycles, button[4] pulsed -> `score`=1, `streak`=1, one `hit_pulse` 3 cycles after the button edge. A second press on bit 4 in the same flick has no effect.
- **Miss and wrong:** `lights`=9'b000000001, button[3] pressed, light clears -> `wrong`=1, `misses`=1, `streak`=0, one `miss_pulse`.
- **Simultaneous:** hit edge on the target in the same cycle `lights` returns to 0 -> `score`+1, `misses` unchanged. Press on bits 2 and 5 with target bit 5 -> hit, `wrong` unchanged.
- **Round end:** ROUND_FLICKS=3, sequence hit, miss, hit -> `round_done`=1 after the third close, with `score`=2, `misses`=1, `best_streak`=1. Dropping `start` goes to IDLE with counters held.
- **Saturation:** SCORE_W=2, 5 consecutive hits -> `score`=3, `streak`=3, `best_streak`=3.
